// File: rtl/memory_stage_mc.sv
// Memory stage for a multi-cycle memory port.
// Drives one request per load/store, holds it stable while the memory
// inserts wait states, aborts after TIMEOUT wait cycles, and registers the
// M->W pipeline boundary. Misaligned accesses and timeouts are reported
// as a one-cycle ErrW with the write-back suppressed.
module memory_stage_mc #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    // M-stage pipeline inputs
    input  logic                RegWriteM,
    input  logic                MemtoRegM,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic                BranchM,
    input  logic                ZeroM,
    input  logic [1:0]          MemSizeM,
    input  logic                MemUnsignedM,
    input  logic [DW-1:0]       ALUOutM,
    input  logic [DW-1:0]       WriteDataM,
    input  logic [RW-1:0]       WriteRegM,
    // memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [DW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic [DW/8-1:0]     mem_be,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                mem_ready,
    // hazard / write-back
    output logic                StallM,
    output logic                PCSrcM,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic                ErrW,
    output logic [DW-1:0]       ALUOutW,
    output logic [DW-1:0]       ReadDataW,
    output logic [RW-1:0]       WriteRegW
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, stateNext;
    logic [7:0]      waitCnt;

    // Request captured on entry to WAIT so the bus stays stable even if
    // upstream values wiggle.
    logic            weR;
    logic [DW-1:0]   addrR;
    logic [DW-1:0]   wdataR;
    logic [NB-1:0]   beR;
    logic [1:0]      sizeR;
    logic            unsR;

    // Decode of the current M-stage instruction
    logic            accessM, isStoreM, isLoadM;
    logic            sizeHalf, sizeWord, misalignM, alignedM;
    logic [OW-1:0]   offM;
    logic [NB-1:0]   beM;
    logic [DW-1:0]   wdataM;

    // Effective request (live in IDLE, captured in WAIT)
    logic            inIdle, inWait;
    logic            weE, unsE, isLoadE;
    logic [1:0]      sizeE;
    logic [DW-1:0]   addrE;
    logic [OW-1:0]   offE;
    logic [DW-1:0]   rdShift, loadData, readDataM;

    logic            timeoutHit, accDone, errM;
    logic            unusedWdata;

    assign PCSrcM = BranchM & ZeroM;

    assign accessM   = MemReadM | MemWriteM;
    assign isStoreM  = MemWriteM;               // write wins when both set
    assign isLoadM   = MemReadM & ~MemWriteM;
    assign sizeHalf  = (MemSizeM == 2'b01);
    assign sizeWord  = MemSizeM[1];             // 10 and reserved 11
    assign misalignM = accessM & ((sizeHalf & ALUOutM[0]) |
                                  (sizeWord & (ALUOutM[1:0] != 2'b00)));
    assign alignedM  = accessM & ~misalignM;
    assign offM      = ALUOutM[OW-1:0];

    // Byte enables and lane-replicated store data for the live request
    always_comb begin
        beM    = '0;
        wdataM = '0;
        if (sizeWord) begin
            beM    = NB'(4'hF) << offM;
            wdataM = {(NB/4){WriteDataM[31:0]}};
        end else if (sizeHalf) begin
            beM    = NB'(2'h3) << offM;
            wdataM = {(NB/2){WriteDataM[15:0]}};
        end else begin
            beM    = NB'(1'b1) << offM;
            wdataM = {NB{WriteDataM[7:0]}};
        end
    end

    // Only the low word of WriteDataM can ever be stored.
    assign unusedWdata = ^WriteDataM;

    assign inIdle = (state == IDLE);
    assign inWait = (state == WAIT);

    assign weE     = inWait ? weR   : isStoreM;
    assign addrE   = inWait ? addrR : ALUOutM;
    assign sizeE   = inWait ? sizeR : MemSizeM;
    assign unsE    = inWait ? unsR  : MemUnsignedM;
    assign isLoadE = inWait ? ~weR  : isLoadM;
    assign offE    = addrE[OW-1:0];

    assign mem_req   = rst & (inWait | (inIdle & alignedM));
    assign mem_we    = weE;
    assign mem_addr  = addrE;
    assign mem_wdata = inWait ? wdataR : wdataM;
    assign mem_be    = inWait ? beR    : beM;

    // Abort happens in the WAIT cycle where the counter has reached TIMEOUT
    // and the memory still has not answered; a late ready in that same
    // cycle still completes the access.
    assign timeoutHit = inWait & ~mem_ready & (waitCnt >= TO);
    assign accDone    = mem_ready & (inWait | (inIdle & alignedM));
    assign errM       = (inIdle & misalignM) | timeoutHit;

    assign StallM = rst & ((inIdle & alignedM & ~mem_ready) |
                           (inWait & ~mem_ready & (waitCnt < TO)));

    // Select the addressed byte/half/word and extend it to DW
    always_comb begin
        rdShift  = mem_rdata >> {offE, 3'b000};
        loadData = '0;
        if (sizeE[1])
            loadData = {{(DW-32){~unsE & rdShift[31]}}, rdShift[31:0]};
        else if (sizeE == 2'b01)
            loadData = {{(DW-16){~unsE & rdShift[15]}}, rdShift[15:0]};
        else
            loadData = {{(DW-8){~unsE & rdShift[7]}}, rdShift[7:0]};
    end

    assign readDataM = (accDone & isLoadE) ? loadData : '0;

    // Next-state logic for the request FSM
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (alignedM & ~mem_ready) stateNext = WAIT;
            WAIT: if (mem_ready | timeoutHit) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register and WAIT-cycle counter (cleared whenever idle)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state <= stateNext;
            if (inWait && waitCnt != 8'hFF)
                waitCnt <= waitCnt + 8'd1;
            else if (!inWait)
                waitCnt <= '0;
        end
    end

    // Capture the request on the IDLE->WAIT transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weR    <= 1'b0;
            addrR  <= '0;
            wdataR <= '0;
            beR    <= '0;
            sizeR  <= '0;
            unsR   <= 1'b0;
        end else if (inIdle && stateNext == WAIT) begin
            weR    <= isStoreM;
            addrR  <= ALUOutM;
            wdataR <= wdataM;
            beR    <= beM;
            sizeR  <= MemSizeM;
            unsR   <= MemUnsignedM;
        end
    end

    // M->W register: load when not stalled, insert a bubble while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ErrW      <= 1'b0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            WriteRegW <= '0;
        end else if (!StallM) begin
            RegWriteW <= RegWriteM & ~errM;
            MemtoRegW <= MemtoRegM & ~errM;
            ErrW      <= errM;
            ALUOutW   <= ALUOutM;
            ReadDataW <= readDataM;
            WriteRegW <= WriteRegM;
        end else begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ErrW      <= 1'b0;
        end
    end

endmodule
